// File: rtl/mips_core_pkg.sv
// Shared definitions for the MIPS core slice.
//   hc_state_t : hazard controller FSM encoding (RUN / PEND_REDIRECT)
//   REG_ZERO   : architectural zero register number; never a hazard source
package mips_core_pkg;

    typedef enum logic [0:0] {
        HC_RUN           = 1'b0,
        HC_PEND_REDIRECT = 1'b1
    } hc_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_controller_sat_counter.sv
// Saturating up-counter used for hazard performance statistics.
//   clk   : clock
//   rst_n : synchronous reset, active low (clears count)
//   inc   : add one this cycle (ignored once count is all-ones)
//   count : current value, holds at all-ones instead of wrapping
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Hazard controller: turns d-cache miss, i-cache miss, load-use and branch
// mispredict conditions into stall/flush controls for the pc register and
// the i2d/d2e/e2m/m2w pipeline registers, plus a pc redirect.
//   clk, rst_n                 : clock, synchronous active-low reset
//   ic_miss, dc_miss           : cache miss indications for this cycle
//   dec_uses_rs/rt, dec_*_addr : source operands of the decode instruction
//   ex_valid, ex_is_load,
//   ex_rw_addr                 : instruction in EX and its destination
//   ex_mispredict,
//   ex_recovery_target         : branch resolution from EX
//   *_stall / *_flush          : per-register hold / bubble controls
//   pc_redirect, redirect_target : load pc with redirect_target
//   cnt_*                      : saturating per-cause cycle counters
// A mispredict that arrives while fetch is blocked by an i-cache miss is
// parked in pend_target and issued once fetch frees up.
module hazard_controller
    import mips_core_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ic_miss,
    input  logic              dc_miss,
    input  logic              dec_uses_rs,
    input  logic [4:0]        dec_rs_addr,
    input  logic              dec_uses_rt,
    input  logic [4:0]        dec_rt_addr,
    input  logic              ex_valid,
    input  logic              ex_is_load,
    input  logic [4:0]        ex_rw_addr,
    input  logic              ex_mispredict,
    input  logic [ADDR_W-1:0] ex_recovery_target,
    output logic              pc_stall,
    output logic              i2d_stall,
    output logic              d2e_stall,
    output logic              e2m_stall,
    output logic              m2w_stall,
    output logic              i2d_flush,
    output logic              d2e_flush,
    output logic              e2m_flush,
    output logic              m2w_flush,
    output logic              pc_redirect,
    output logic [ADDR_W-1:0] redirect_target,
    output logic [CNT_W-1:0]  cnt_dc_stall,
    output logic [CNT_W-1:0]  cnt_ic_stall,
    output logic [CNT_W-1:0]  cnt_ld_use,
    output logic [CNT_W-1:0]  cnt_mispredict
);

    hc_state_t         state, state_next;
    logic [ADDR_W-1:0] pend_target, pend_target_next;
    logic              load_use;
    logic              inc_dc, inc_ic, inc_ld, inc_mp;

    // Register 0 is hard-wired, so a load targeting it never blocks decode.
    always_comb begin
        load_use = ex_valid && ex_is_load && (ex_rw_addr != REG_ZERO) &&
                   ((dec_uses_rs && (dec_rs_addr == ex_rw_addr)) ||
                    (dec_uses_rt && (dec_rt_addr == ex_rw_addr)));
    end

    // Priority decision; first matching cause owns the whole cycle.
    always_comb begin
        pc_stall         = 1'b0;
        i2d_stall        = 1'b0;
        d2e_stall        = 1'b0;
        e2m_stall        = 1'b0;
        m2w_stall        = 1'b0;
        i2d_flush        = 1'b0;
        d2e_flush        = 1'b0;
        e2m_flush        = 1'b0;
        m2w_flush        = 1'b0;
        pc_redirect      = 1'b0;
        redirect_target  = '0;
        state_next       = state;
        pend_target_next = pend_target;
        inc_dc           = 1'b0;
        inc_ic           = 1'b0;
        inc_ld           = 1'b0;
        inc_mp           = 1'b0;

        if (!rst_n) begin
            i2d_flush = 1'b1;
            d2e_flush = 1'b1;
            e2m_flush = 1'b1;
            m2w_flush = 1'b1;
        end else if (dc_miss) begin
            // Branch in EX is frozen too; its mispredict is seen again later.
            pc_stall  = 1'b1;
            i2d_stall = 1'b1;
            d2e_stall = 1'b1;
            e2m_stall = 1'b1;
            m2w_flush = 1'b1;
            inc_dc    = 1'b1;
        end else if (ex_valid && ex_mispredict) begin
            i2d_flush = 1'b1;
            d2e_flush = 1'b1;
            inc_mp    = 1'b1;
            if (ic_miss) begin
                pc_stall         = 1'b1;
                inc_ic           = 1'b1;
                pend_target_next = ex_recovery_target;
                state_next       = HC_PEND_REDIRECT;
            end else begin
                pc_redirect     = 1'b1;
                redirect_target = ex_recovery_target;
            end
        end else if (state == HC_PEND_REDIRECT) begin
            i2d_flush = 1'b1;
            if (ic_miss) begin
                pc_stall = 1'b1;
                inc_ic   = 1'b1;
            end else begin
                pc_redirect     = 1'b1;
                redirect_target = pend_target;
                state_next      = HC_RUN;
            end
        end else if (load_use) begin
            pc_stall  = 1'b1;
            i2d_stall = 1'b1;
            d2e_flush = 1'b1;
            inc_ld    = 1'b1;
        end else if (ic_miss) begin
            pc_stall  = 1'b1;
            i2d_flush = 1'b1;
            inc_ic    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= HC_RUN;
            pend_target <= '0;
        end else begin
            state       <= state_next;
            pend_target <= pend_target_next;
        end
    end

    sat_counter #(.W(CNT_W)) u_cnt_dc (
        .clk(clk), .rst_n(rst_n), .inc(inc_dc), .count(cnt_dc_stall)
    );
    sat_counter #(.W(CNT_W)) u_cnt_ic (
        .clk(clk), .rst_n(rst_n), .inc(inc_ic), .count(cnt_ic_stall)
    );
    sat_counter #(.W(CNT_W)) u_cnt_ld (
        .clk(clk), .rst_n(rst_n), .inc(inc_ld), .count(cnt_ld_use)
    );
    sat_counter #(.W(CNT_W)) u_cnt_mp (
        .clk(clk), .rst_n(rst_n), .inc(inc_mp), .count(cnt_mispredict)
    );

endmodule
